// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
//   Round-robin scheduler sharing one SPI master datapath among NREQ
//   requesters. A granted requester's byte is latched and a one-cycle
//   send_data_o pulse starts the frame. The arbiter then waits for
//   receive_data_i, returns the received byte with a done/error pulse and
//   holds off for GAP cycles so slave select drops between frames.
//
// Ports
//   PCLK, PRESET      clock, synchronous active-high reset
//   enable_i          datapath usable; grants only issued while high
//   req_i[NREQ]       level requests, held until done
//   tx_data_i         packed per-requester tx bytes, requester n at [n*DW +: DW]
//   gnt_o[NREQ]       one-hot grant, grant edge through end of WAIT
//   done_o[NREQ]      one-cycle completion pulse to the granted requester
//   err_o             one-cycle abort flag, coincident with done_o
//   rx_data_o         captured receive byte, held until next capture
//   tx_data_o         latched byte to the shifter
//   send_data_o       one-cycle frame start pulse
//   receive_data_i    one-cycle end-of-frame pulse from datapath
//   rx_shift_i        shifter parallel data, valid with receive_data_i
//   busy_o            arbiter not idle
//   tmo_flag_o        sticky timeout flag, cleared by err_clr_i
module spi_xfer_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 2,
  parameter int TMO  = 4096
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               enable_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] tx_data_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               err_o,
  output logic [DW-1:0]      rx_data_o,
  output logic [DW-1:0]      tx_data_o,
  output logic               send_data_o,
  input  logic               receive_data_i,
  input  logic [DW-1:0]      rx_shift_i,
  output logic               busy_o,
  output logic               tmo_flag_o,
  input  logic               err_clr_i
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TMO);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_GAP} state_t;

  state_t              r_state, w_state_next;
  logic [IW-1:0]       r_last, w_last_next;
  logic [NREQ-1:0]     r_gnt, w_gnt_next;
  logic [NREQ-1:0]     r_done, w_done_next;
  logic                r_err, w_err_next;
  logic [DW-1:0]       r_rx, w_rx_next;
  logic [DW-1:0]       r_tx, w_tx_next;
  logic                r_send, w_send_next;
  logic [TW-1:0]       r_timer, w_timer_next;
  logic [GW-1:0]       r_gap, w_gap_next;
  logic                r_tmo_flag, w_tmo_flag_next;

  // Round-robin pick: rotate the request vector so bit 0 is (last+1),
  // take the lowest set bit, then map the offset back to a requester.
  logic [2*NREQ-1:0]   w_dbl;
  logic [IW:0]         w_base;
  logic [NREQ-1:0]     w_rot;
  logic [NREQ-1:0]     w_hit;
  logic [IW-1:0]       w_off_acc [NREQ+1];
  logic [IW+1:0]       w_sum;
  logic [IW-1:0]       w_sel;
  logic [DW-1:0]       w_tx_arr [NREQ];

  assign w_dbl  = {req_i, req_i};
  assign w_base = {1'b0, r_last} + 1'b1;
  assign w_rot  = w_dbl[w_base +: NREQ];
  assign w_off_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pick
      assign w_hit[gi] = w_rot[gi] & ~(|(w_rot & ((NREQ'(1) << gi) - NREQ'(1))));
      assign w_off_acc[gi+1] = w_off_acc[gi] | (w_hit[gi] ? IW'(gi) : '0);
      assign w_tx_arr[gi] = tx_data_i[gi*DW +: DW];
    end
  endgenerate

  assign w_sum = {1'b0, w_base} + {2'b00, w_off_acc[NREQ]};
  assign w_sel = (w_sum >= (IW+2)'(NREQ)) ? IW'(w_sum - (IW+2)'(NREQ)) : IW'(w_sum);

  always_comb begin
    w_state_next    = r_state;
    w_last_next     = r_last;
    w_gnt_next      = r_gnt;
    w_done_next     = '0;
    w_err_next      = 1'b0;
    w_rx_next       = r_rx;
    w_tx_next       = r_tx;
    w_send_next     = 1'b0;
    w_timer_next    = r_timer;
    w_gap_next      = r_gap;
    w_tmo_flag_next = err_clr_i ? 1'b0 : r_tmo_flag;

    case (r_state)
      ST_IDLE: begin
        if (enable_i && (|req_i)) begin
          w_gnt_next   = NREQ'(1) << w_sel;
          w_tx_next    = w_tx_arr[w_sel];
          w_last_next  = w_sel;
          w_send_next  = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_timer_next = '0;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_timer_next = r_timer + 1'b1;
        if (receive_data_i || !enable_i || (r_timer == TW'(TMO-1))) begin
          w_done_next  = r_gnt;
          // A frame end coinciding with timeout or enable loss still counts
          // as success.
          w_err_next   = !receive_data_i;
          w_gnt_next   = '0;
          w_gap_next   = '0;
          w_state_next = ST_GAP;
          if (receive_data_i)
            w_rx_next = rx_shift_i;
          else if (enable_i)
            w_tmo_flag_next = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == GW'(GAP-1))
          w_state_next = ST_IDLE;
        else
          w_gap_next = r_gap + 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_last     <= IW'(NREQ-1);
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_send     <= 1'b0;
      r_timer    <= '0;
      r_gap      <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_gnt      <= w_gnt_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_rx       <= w_rx_next;
      r_tx       <= w_tx_next;
      r_send     <= w_send_next;
      r_timer    <= w_timer_next;
      r_gap      <= w_gap_next;
      r_tmo_flag <= w_tmo_flag_next;
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rx_data_o   = r_rx;
  assign tx_data_o   = r_tx;
  assign send_data_o = r_send;
  assign busy_o      = (r_state != ST_IDLE);
  assign tmo_flag_o  = r_tmo_flag;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Testbench for spi_xfer_arbiter: directed scenarios with literal
// expectations plus a transaction-level model compared every cycle.
module tb_spi_xfer_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int TMO  = 64;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic               enable_i;
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] tx_data_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic               err_o;
  logic [DW-1:0]      rx_data_o;
  logic [DW-1:0]      tx_data_o;
  logic               send_data_o;
  logic               receive_data_i;
  logic [DW-1:0]      rx_shift_i;
  logic               busy_o;
  logic               tmo_flag_o;
  logic               err_clr_i;

  spi_xfer_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .TMO(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable_i(enable_i), .req_i(req_i),
    .tx_data_i(tx_data_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rx_data_o(rx_data_o), .tx_data_o(tx_data_o), .send_data_o(send_data_o),
    .receive_data_i(receive_data_i), .rx_shift_i(rx_shift_i), .busy_o(busy_o),
    .tmo_flag_o(tmo_flag_o), .err_clr_i(err_clr_i)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checking = 1'b0;
  int send_q[$];
  int send_cyc[$];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is tracked by the number of edges since its grant: edge 0
  // is the grant (send pulse), edges >= 1 are waiting cycles; the wait
  // expires on the TMO-th waiting cycle. After completion GAP idle edges
  // must pass before the arbiter may grant again.
  bit              m_active;
  int              m_t;
  int              m_gap_left;
  int              m_last;
  int              m_sel;
  logic [NREQ-1:0] m_done;
  logic            m_err;
  logic            m_send;
  logic [DW-1:0]   m_rx;
  logic [DW-1:0]   m_tx;
  logic            m_flag;

  function automatic int pick(input int last, input logic [NREQ-1:0] r);
    logic [2*NREQ-1:0] d;
    d = {r, r} >> (last + 1);
    for (int i = 0; i < NREQ; i++)
      if (d[i]) return (last + 1 + i) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge PCLK) begin
    m_done <= '0;
    m_err  <= 1'b0;
    m_send <= 1'b0;
    if (PRESET) begin
      m_active   <= 1'b0;
      m_t        <= 0;
      m_gap_left <= 0;
      m_last     <= NREQ - 1;
      m_sel      <= 0;
      m_rx       <= '0;
      m_tx       <= '0;
      m_flag     <= 1'b0;
    end else begin
      if (err_clr_i) m_flag <= 1'b0;
      if (m_gap_left > 0) m_gap_left <= m_gap_left - 1;
      if (m_active) begin
        if (m_t == 0) begin
          m_t <= 1;
        end else if (receive_data_i || !enable_i || m_t == TMO) begin
          m_active   <= 1'b0;
          m_gap_left <= GAP;
          m_done     <= onehot(m_sel);
          m_err      <= !receive_data_i;
          if (receive_data_i) m_rx <= rx_shift_i;
          else if (enable_i) m_flag <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (m_gap_left == 0 && enable_i && req_i != '0) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_sel    <= pick(m_last, req_i);
        m_last   <= pick(m_last, req_i);
        m_send   <= 1'b1;
        m_tx     <= tx_data_i[pick(m_last, req_i)*DW +: DW];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge PCLK) begin
    if (checking) begin
      chk("gnt",  gnt_o,       m_active ? onehot(m_sel) : '0);
      chk("done", done_o,      m_done);
      chk("err",  err_o,       m_err);
      chk("send", send_data_o, m_send);
      chk("rx",   rx_data_o,   m_rx);
      chk("tx",   tx_data_o,   m_tx);
      chk("busy", busy_o,      (m_active || m_gap_left > 0) ? 1'b1 : 1'b0);
      chk("tmo",  tmo_flag_o,  m_flag);
    end
  end

  // Log every frame start with the granted requester index.
  always @(negedge PCLK) begin
    if (send_data_o === 1'b1) begin
      int idx;
      idx = -1;
      for (int i = 0; i < NREQ; i++) if (gnt_o[i]) idx = i;
      send_q.push_back(idx);
      send_cyc.push_back(cyc);
    end
  end

  task automatic wait_send(input string name);
    int n;
    n = 0;
    while (send_data_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (send_data_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_send: got no send_data_o expected pulse within 40 cycles", name);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    PRESET = 1'b1; enable_i = 1'b0; req_i = '0; tx_data_i = '0;
    receive_data_i = 1'b0; rx_shift_i = '0; err_clr_i = 1'b0;
    tick();
    checking = 1'b1;
    tick(); tick();
    PRESET = 1'b0;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_send", send_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx", tx_data_o, 0);

    // 1: single transfer from requester 0
    enable_i = 1'b1; req_i = 4'b0001;
    tx_data_i = {8'h44, 8'h33, 8'h22, 8'hA5};
    tick();
    chk("t1_gnt", gnt_o, 4'b0001);
    chk("t1_tx", tx_data_o, 8'hA5);
    chk("t1_send", send_data_o, 1);
    tick();
    chk("t1_send_low", send_data_o, 0);
    repeat (19) tick();
    receive_data_i = 1'b1; rx_shift_i = 8'h3C;
    tick();
    receive_data_i = 1'b0; req_i = '0;
    chk("t1_done", done_o, 4'b0001);
    chk("t1_rx", rx_data_o, 8'h3C);
    chk("t1_err", err_o, 0);
    repeat (GAP - 1) tick();
    chk("t1_done_clr", done_o, 0);
    chk("t1_busy_gap", busy_o, 1);
    tick();
    chk("t1_busy_low", busy_o, 0);

    // 2: round-robin with all requests held
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    send_q.delete(); send_cyc.delete();
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_send("t2");
      repeat (5) tick();
      receive_data_i = 1'b1; rx_shift_i = 8'h10 + 8'(n);
      tick();
      receive_data_i = 1'b0;
      if (n == 4) req_i = '0;
    end
    chk("t2_nsend", send_q.size(), 5);
    if (send_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), send_q[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk($sformatf("t2_space%0d", i), send_cyc[i] - send_cyc[i-1], 1 + 5 + GAP + 1);
    end
    repeat (GAP + 2) tick();

    // 3: timeout on requester 2, sticky flag and clear
    req_i = 4'b0100;
    wait_send("t3");
    repeat (TMO + 1) tick();
    chk("t3_done", done_o, 4'b0100);
    chk("t3_err", err_o, 1);
    chk("t3_flag", tmo_flag_o, 1);
    req_i = '0;
    repeat (10) tick();
    chk("t3_flag_sticky", tmo_flag_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t3_flag_clr", tmo_flag_o, 0);

    // 4: enable loss during WAIT, then no grant while disabled
    req_i = 4'b0001;
    wait_send("t4");
    repeat (3) tick();
    enable_i = 1'b0;
    tick();
    chk("t4_done", done_o, 4'b0001);
    chk("t4_err", err_o, 1);
    chk("t4_flag", tmo_flag_o, 0);
    n0 = send_q.size();
    repeat (10) tick();
    chk("t4_nogrant", send_q.size(), n0);
    chk("t4_gnt", gnt_o, 0);
    req_i = '0; enable_i = 1'b1;
    tick();

    // 5: frame end on the timeout cycle wins; frame end in IDLE ignored
    req_i = 4'b0010;
    wait_send("t5");
    repeat (TMO) tick();
    receive_data_i = 1'b1; rx_shift_i = 8'h5A;
    tick();
    receive_data_i = 1'b0; req_i = '0;
    chk("t5_done", done_o, 4'b0010);
    chk("t5_err", err_o, 0);
    chk("t5_rx", rx_data_o, 8'h5A);
    chk("t5_flag", tmo_flag_o, 0);
    repeat (GAP + 3) tick();
    receive_data_i = 1'b1; rx_shift_i = 8'hEE;
    tick();
    receive_data_i = 1'b0;
    chk("t5_idle_done", done_o, 0);
    chk("t5_idle_rx", rx_data_o, 8'h5A);

    // 6: reset during WAIT, then requester 0 first against 1001
    req_i = 4'b0010;
    wait_send("t6");
    repeat (3) tick();
    PRESET = 1'b1;
    tick();
    chk("t6_gnt", gnt_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_send", send_data_o, 0);
    chk("t6_rx", rx_data_o, 0);
    chk("t6_tx", tx_data_o, 0);
    chk("t6_busy", busy_o, 0);
    PRESET = 1'b0; req_i = 4'b1001;
    tick();
    chk("t6_gnt0", gnt_o, 4'b0001);
    chk("t6_tx0", tx_data_o, 8'hA5);
    chk("t6_send0", send_data_o, 1);
    repeat (4) tick();
    receive_data_i = 1'b1; rx_shift_i = 8'h77;
    tick();
    receive_data_i = 1'b0; req_i = '0;
    chk("t6_done0", done_o, 4'b0001);
    chk("t6_rx0", rx_data_o, 8'h77);
    repeat (GAP + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Round-robin scheduler that shares one SPI master datapath (slave-select/timing block plus shifter) among NREQ requesters.
- Grants one requester at a time and latches its transmit byte.
- Issues a single-cycle send_data pulse, then waits for the datapath's receive_data pulse.
- Returns the received byte and a done/error pulse to the granted requester, then enforces an inter-frame gap so slave select deasserts between frames.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, transfer data width in bits
- GAP, 2, idle cycles forced between transfers (>=1)
- TMO, 4096, WAIT-state cycles before timeout abort (>=2)

Ports:
- PCLK  in  1  system clock, all logic on rising edge
- PRESET  in  1  synchronous active-high reset
- enable_i  in  1  datapath usable (master mode, mode valid, not in wait-stop)
- req_i  in  NREQ  per-requester transfer request, level, held until done
- tx_data_i  in  NREQ*DW  per-requester tx byte, requester n at bits [n*DW +: DW]
- gnt_o  out  NREQ  one-hot grant, high from grant through end of WAIT
- done_o  out  NREQ  one-cycle completion pulse to granted requester
- err_o  out  1  one-cycle, coincident with done_o, transfer aborted (timeout or enable loss)
- rx_data_o  out  DW  received byte, valid in done_o cycle, held until next capture
- tx_data_o  out  DW  latched byte to shifter
- send_data_o  out  1  one-cycle start pulse to slave-select block
- receive_data_i  in  1  one-cycle end-of-frame pulse from slave-select block
- rx_shift_i  in  DW  shifter parallel receive data, valid with receive_data_i
- busy_o  out  1  state != IDLE
- tmo_flag_o  out  1  sticky, set on timeout
- err_clr_i  in  1  clears tmo_flag_o

Behaviour:
- Reset (PRESET high at an edge): state=IDLE; gnt_o=0, done_o=0, err_o=0, send_data_o=0, tx_data_o=0, rx_data_o=0, tmo_flag_o=0; last-grant pointer=NREQ-1, so requester 0 has first priority. Reset mid-transfer aborts silently, with no done_o.
- States are IDLE, START, WAIT, GAP.
- IDLE:
  - If enable_i=1 and any req_i bit is set, select the first set bit searching from (last+1) mod NREQ upward with wrap.
  - At that edge: gnt_o=onehot(sel), tx_data_o=tx_data_i[sel], last=sel, send_data_o=1, state->START.
  - If enable_i=0, requests are ignored.
- START: exactly one cycle. At the next edge send_data_o=0, wait-timer=0, state->WAIT. Latency from the sampling edge of req to send_data_o high is 0 cycles, because send_data_o is registered at that edge.
- WAIT: the timer increments each cycle. Conditions are evaluated in priority order:
  - (1) receive_data_i=1: rx_data_o<=rx_shift_i, done_o[sel]=1, err_o=0.
  - (2) enable_i=0: done_o[sel]=1, err_o=1, rx_data_o unchanged.
  - (3) timer==TMO-1: done_o[sel]=1, err_o=1, tmo_flag_o=1.
  - Any of these: gnt_o<=0, gap counter=0, state->GAP.
  - receive_data_i coincident with a timeout counts as success.
- GAP: done_o and err_o return to 0 after one cycle. Stays in GAP for GAP cycles, then state->IDLE. No grant is issued in GAP, so a new send_data_o can occur no earlier than GAP+1 cycles after done_o.
- A requester dropping req_i after grant does not cancel the transfer; completion still pulses done_o.
- tx_data_i changes after grant do not affect tx_data_o.
- receive_data_i outside WAIT is ignored.
- err_clr_i clears tmo_flag_o. A timeout set in the same cycle wins.
- Round-robin fairness: with all requests held continuously, grants rotate 0,1,...,NREQ-1,0.
- At most one gnt_o bit and at most one done_o bit is high in any cycle.

Test Plan:
- Reset, enable_i=1, req_i=0001, tx_data_i[0]=8'hA5 -> next edge gnt_o=0001, tx_data_o=A5, send_data_o high exactly 1 cycle. Drive receive_data_i with rx_shift_i=8'h3C 20 cycles later -> done_o=0001 for 1 cycle, rx_data_o=3C, err_o=0, busy_o low GAP cycles later.
- req_i=1111 held, auto-respond receive_data_i 5 cycles after each send_data_o -> grant order 0,1,2,3,0. Spacing between send_data_o pulses is 1+5+GAP+1 cycles.
- Grant requester 2, never pulse receive_data_i -> after TMO cycles in WAIT, done_o=0100 with err_o=1, tmo_flag_o=1. tmo_flag_o stays 1 until err_clr_i is pulsed, then reads 0.
- During WAIT deassert enable_i -> next edge done_o pulse, err_o=1, tmo_flag_o unchanged. With req held and enable_i=0 in IDLE -> no grant, send_data_o stays 0.
- receive_data_i in the same cycle as timer==TMO-1 -> err_o=0, rx_data_o captured. receive_data_i pulsed in IDLE -> no done_o.
- Assert PRESET during WAIT -> next edge all outputs 0, state IDLE, no done_o. Requester 0 then wins first against req_i=1001.
